// File: rtl/ad9866_spi_sched.sv
// AD9866 SPI sequencer: codec reset, init-table streaming, then gain/host write arbitration.
// One 16-bit frame per SHIFT; gain writes coalesce to the latest rx_gain and outrank host writes.
module ad9866_spi_sched #(
  parameter int         CLKDIV    = 4,
  parameter int         NINIT     = 13,
  parameter int         RSTCYC    = 64,
  parameter logic [5:0] GAIN_ADDR = 6'h09
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [4:0]  init_idx,
  input  logic [15:0] init_word,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [5:0]  host_addr,
  input  logic [7:0]  host_data,
  input  logic [5:0]  rx_gain,
  input  logic        gain_en,
  output logic        busy,
  output logic        init_done,
  output logic        ad9866_rst_n,
  output logic        ad9866_sen_n,
  output logic        ad9866_sclk,
  output logic        ad9866_sdio
);

  localparam int CW = $clog2(RSTCYC + 2*CLKDIV + 1);
  localparam int DW = $clog2(CLKDIV + 1);

  typedef enum logic [2:0] {
    S_RST_HOLD, S_RST_WAIT, S_INIT, S_IDLE, S_SHIFT, S_GAP
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_div;
  logic [4:0]    r_bit;
  logic          r_half;
  logic [15:0]   r_sr;
  logic [5:0]    r_gain_last;
  logic          r_init_done;
  logic [4:0]    r_init_idx;
  logic          r_rst_n, r_sen_n, r_sclk, r_sdio, r_busy;

  logic          w_gain_pend, w_host_rdy, w_gain_go, w_host_go, w_load;
  logic          w_div_end, w_tail, w_last_init, w_rst_done, w_gap_done;
  logic [15:0]   w_frame;
  logic          w_rst_n_nxt, w_sen_n_nxt, w_sclk_nxt, w_sdio_nxt, w_busy_nxt;

  assign w_gain_pend = gain_en && r_init_done && (rx_gain != r_gain_last);
  assign w_host_rdy  = (r_state == S_IDLE) && r_init_done && !w_gain_pend;
  assign w_gain_go   = (r_state == S_IDLE) && w_gain_pend;
  assign w_host_go   = w_host_rdy && host_valid;
  assign w_load      = (r_state == S_INIT) || w_gain_go || w_host_go;
  assign w_div_end   = (r_div == DW'(CLKDIV - 1));
  assign w_tail      = (r_bit == 5'd16);
  assign w_last_init = (r_init_idx == 5'(NINIT - 1));
  assign w_rst_done  = (r_cnt == CW'(RSTCYC - 1));
  assign w_gap_done  = (r_state == S_GAP) && (r_cnt == CW'(2*CLKDIV - 1));

  always_comb begin
    w_frame = {2'b00, host_addr, host_data};
    if (r_state == S_INIT) w_frame = init_word;
    else if (w_gain_go)    w_frame = {2'b00, GAIN_ADDR, 2'b01, rx_gain};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_RST_HOLD;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RST_HOLD: if (w_rst_done) w_next = S_RST_WAIT;
      S_RST_WAIT: if (w_rst_done) w_next = S_INIT;
      S_INIT:     w_next = S_SHIFT;
      S_IDLE:     if (w_gain_go || w_host_go) w_next = S_SHIFT;
      S_SHIFT:    if (w_div_end && w_tail) w_next = S_GAP;
      S_GAP:      if (w_gap_done) w_next = (!r_init_done && !w_last_init) ? S_INIT : S_IDLE;
      default:    w_next = S_RST_HOLD;
    endcase
  end

  // Next values of the registered pins; sdio only moves when sclk falls.
  always_comb begin
    w_rst_n_nxt = (w_next != S_RST_HOLD);
    w_sen_n_nxt = (w_next != S_SHIFT);
    w_busy_nxt  = (w_next != S_IDLE);
    w_sclk_nxt  = r_sclk;
    w_sdio_nxt  = r_sdio;
    if (r_state != S_SHIFT) begin
      w_sclk_nxt = 1'b0;
      w_sdio_nxt = w_load ? w_frame[15] : 1'b0;
    end else if (w_div_end) begin
      if (w_tail) begin
        w_sclk_nxt = 1'b0;
        w_sdio_nxt = 1'b0;
      end else if (!r_half) begin
        w_sclk_nxt = 1'b1;
      end else begin
        w_sclk_nxt = 1'b0;
        w_sdio_nxt = r_sr[14];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt       <= '0;
      r_div       <= '0;
      r_bit       <= '0;
      r_half      <= 1'b0;
      r_sr        <= '0;
      r_gain_last <= 6'h3F;
      r_init_done <= 1'b0;
      r_init_idx  <= '0;
      r_rst_n     <= 1'b0;
      r_sen_n     <= 1'b1;
      r_sclk      <= 1'b0;
      r_sdio      <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_rst_n <= w_rst_n_nxt;
      r_sen_n <= w_sen_n_nxt;
      r_sclk  <= w_sclk_nxt;
      r_sdio  <= w_sdio_nxt;
      r_busy  <= w_busy_nxt;

      if (r_state != w_next) r_cnt <= '0;
      else if (r_state == S_RST_HOLD || r_state == S_RST_WAIT || r_state == S_GAP)
        r_cnt <= r_cnt + CW'(1);

      if (w_load) begin
        r_sr   <= w_frame;
        r_div  <= '0;
        r_bit  <= '0;
        r_half <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        if (w_div_end) begin
          r_div <= '0;
          if (!w_tail) begin
            r_half <= !r_half;
            if (r_half) begin
              r_bit <= r_bit + 5'd1;
              r_sr  <= {r_sr[14:0], 1'b0};
            end
          end
        end else begin
          r_div <= r_div + DW'(1);
        end
      end

      if (w_gain_go) r_gain_last <= rx_gain;

      if (w_gap_done && !r_init_done) begin
        if (w_last_init) r_init_done <= 1'b1;
        else             r_init_idx  <= r_init_idx + 5'd1;
      end
    end
  end

  assign init_idx     = r_init_idx;
  assign host_ready   = w_host_rdy;
  assign busy         = r_busy;
  assign init_done    = r_init_done;
  assign ad9866_rst_n = r_rst_n;
  assign ad9866_sen_n = r_sen_n;
  assign ad9866_sclk  = r_sclk;
  assign ad9866_sdio  = r_sdio;

endmodule
